// File: rtl/seg7_capture_decoder.sv
// Seven-segment capture decoder: watches the segment bus and display enable,
// waits for a pattern to stay stable for STABLE_CYCLES samples, then decodes
// it back to a hex digit and flags patterns that are not legal hex glyphs.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   seg[6:0]     - segment pattern (bit6=g .. bit0=a)
//   en           - display enable; low means blank/invalid
//   digit[3:0]   - last captured decoded value
//   data_valid   - one-cycle pulse on each capture
//   pat_err      - last capture was not a legal hex pattern
//   busy         - a pattern is settling
//   capture_cnt  - captures since reset, wraps
//
// Build option: define SEG_ACTIVE_LOW_EN for common-anode (active-low) segments;
// the bus is inverted at the input register so all later logic is active-high.
module seg7_capture_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg,
  input  logic             en,
  output logic [3:0]       digit,
  output logic             data_valid,
  output logic             pat_err,
  output logic             busy,
  output logic [CNT_W-1:0] capture_cnt
);

  localparam int unsigned STAB_W = 4;
  localparam int unsigned SEG_W  = 7;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t            state, state_d;
  logic [STAB_W-1:0] stab_cnt, stab_d;
  logic [SEG_W-1:0]  seg_q, seg_prev;
  logic              en_q;
  logic              capture_c;
  logic              active_c, same_c;
  logic [3:0]        dec_c;
  logic              legal_c;

  // Input sample registers; seg_prev holds the sample before seg_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '0;
      seg_prev <= '0;
      en_q     <= 1'b0;
    end else begin
`ifdef SEG_ACTIVE_LOW_EN
      seg_q    <= ~seg;
`else
      seg_q    <= seg;
`endif
      seg_prev <= seg_q;
      en_q     <= en;
    end
  end

  // Pattern to hex decode
  always_comb begin
    dec_c   = 4'h0;
    legal_c = 1'b1;
    case (seg_q)
      7'h3F: dec_c = 4'h0;
      7'h06: dec_c = 4'h1;
      7'h5B: dec_c = 4'h2;
      7'h4F: dec_c = 4'h3;
      7'h66: dec_c = 4'h4;
      7'h6D: dec_c = 4'h5;
      7'h7D: dec_c = 4'h6;
      7'h07: dec_c = 4'h7;
      7'h7F: dec_c = 4'h8;
      7'h6F: dec_c = 4'h9;
      7'h77: dec_c = 4'hA;
      7'h7C: dec_c = 4'hB;
      7'h39: dec_c = 4'hC;
      7'h5E: dec_c = 4'hD;
      7'h79: dec_c = 4'hE;
      7'h71: dec_c = 4'hF;
      default: legal_c = 1'b0;
    endcase
  end

  assign active_c = en_q && (seg_q != '0);
  assign same_c   = (seg_q == seg_prev);

  // Next-state logic; capture fires on the edge the stability count reaches
  // STABLE_CYCLES, which also covers STABLE_CYCLES=1 straight out of IDLE/HOLD
  always_comb begin
    state_d   = state;
    stab_d    = stab_cnt;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (active_c) begin
          state_d = SETTLE;
          stab_d  = STAB_W'(1);
        end
      end
      SETTLE: begin
        if (!active_c) begin
          state_d = IDLE;
          stab_d  = '0;
        end else if (same_c) begin
          stab_d  = stab_cnt + STAB_W'(1);
        end else begin
          stab_d  = STAB_W'(1);
        end
      end
      HOLD: begin
        if (!active_c) begin
          state_d = IDLE;
          stab_d  = '0;
        end else if (!same_c) begin
          state_d = SETTLE;
          stab_d  = STAB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        stab_d  = '0;
      end
    endcase
    if (state_d == SETTLE && stab_d == STAB_W'(STABLE_CYCLES)) begin
      capture_c = 1'b1;
      state_d   = HOLD;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stab_cnt    <= '0;
      digit       <= '0;
      data_valid  <= 1'b0;
      pat_err     <= 1'b0;
      busy        <= 1'b0;
      capture_cnt <= '0;
    end else begin
      state      <= state_d;
      stab_cnt   <= stab_d;
      data_valid <= capture_c;
      busy       <= (state_d == SETTLE);
      if (capture_c) begin
        capture_cnt <= capture_cnt + CNT_W'(1);
        pat_err     <= !legal_c;
        if (legal_c) digit <= dec_c;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: directed plus random segment streams checked
// against a run-length reference model (a capture happens when a run of
// identical enabled non-blank samples reaches STABLE_CYCLES).
module tb_seg7_capture_decoder;

  localparam int unsigned S     = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [6:0]       seg;
  logic             en;
  logic [3:0]       digit;
  logic             data_valid;
  logic             pat_err;
  logic             busy;
  logic [CNT_W-1:0] capture_cnt;

  seg7_capture_decoder #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .en(en), .digit(digit),
    .data_valid(data_valid), .pat_err(pat_err), .busy(busy),
    .capture_cnt(capture_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state (logical, active-high segment domain)
  int         run_len;
  logic [6:0] run_pat;
  logic [6:0] prev_s;
  logic       prev_e;
  int         total;
  logic [3:0] exp_digit;
  logic       exp_err, exp_dv, exp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run_len = 0; run_pat = '0; prev_s = '0; prev_e = 1'b0; total = 0;
    exp_digit = '0; exp_err = 1'b0; exp_dv = 1'b0; exp_busy = 1'b0;
  endtask

  // Apply one registered sample to the model: outputs after the next edge
  task automatic model_step(input logic [6:0] s, input logic e);
    bit valid;
    int idx;
    valid = e && (s != 7'h00);
    if (!valid) run_len = 0;
    else if (run_len > 0 && s == run_pat) run_len++;
    else begin run_pat = s; run_len = 1; end
    exp_dv   = valid && (run_len == S);
    exp_busy = valid && (run_len < S);
    if (exp_dv) begin
      total++;
      idx = -1;
      for (int i = 0; i < 16; i++) if (pat_tab[i] == s) idx = i;
      if (idx >= 0) begin exp_digit = 4'(idx); exp_err = 1'b0; end
      else exp_err = 1'b1;
    end
  endtask

  task automatic check_all();
    check("data_valid",  32'(data_valid),  32'(exp_dv));
    check("busy",        32'(busy),        32'(exp_busy));
    check("digit",       32'(digit),       32'(exp_digit));
    check("pat_err",     32'(pat_err),     32'(exp_err));
    check("capture_cnt", 32'(capture_cnt), 32'(total % 256));
  endtask

  // Drive one sample (called just after a posedge), advance a cycle, check
  task automatic cycle(input logic [6:0] s, input logic e);
`ifdef SEG_ACTIVE_LOW_EN
    seg = ~s;
`else
    seg = s;
`endif
    en = e;
    @(posedge clk); #1;
    model_step(prev_s, prev_e);
    check_all();
    prev_s = s;
    prev_e = e;
  endtask

  task automatic hold(input logic [6:0] s, input logic e, input int n);
    for (int i = 0; i < n; i++) cycle(s, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle_idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_digit", 32'(digit), 32'h0);
    check("rst_dv",    32'(data_valid), 32'h0);
    check("rst_err",   32'(pat_err), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_cnt",   32'(capture_cnt), 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cycle_idle_inputs();
`ifdef SEG_ACTIVE_LOW_EN
    seg = 7'h7F;
`else
    seg = 7'h00;
`endif
    en = 1'b0;
  endtask

  initial begin
    logic [6:0] s;
    int k;
    rst_n = 1'b0;
    cycle_idle_inputs();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single stable pattern
    hold(7'h06, 1'b1, 6);
    check("tp1_digit", 32'(digit), 32'h1);
    check("tp1_cnt",   32'(capture_cnt), 32'h1);
    hold(7'h00, 1'b0, 2);

    // Short-lived pattern then a stable one
    do_reset();
    hold(7'h5B, 1'b1, 2);
    hold(7'h4F, 1'b1, 6);
    check("tp2_digit", 32'(digit), 32'h3);
    check("tp2_cnt",   32'(capture_cnt), 32'h1);

    // Legal then illegal
    hold(7'h7F, 1'b1, 6);
    hold(7'h12, 1'b1, 6);
    check("tp3_digit", 32'(digit), 32'h8);
    check("tp3_err",   32'(pat_err), 32'h1);

    // Enable dropout forces a re-capture
    do_reset();
    hold(7'h6D, 1'b1, 6);
    cycle(7'h6D, 1'b0);
    hold(7'h6D, 1'b1, 6);
    check("tp4_cnt", 32'(capture_cnt), 32'h2);

    // Full table, then drive past the counter wrap
    do_reset();
    for (int i = 0; i < 16; i++) hold(pat_tab[i], 1'b1, 5);
    check("tp5_cnt", 32'(capture_cnt), 32'h10);
    for (int r = 0; r < 15; r++)
      for (int i = 0; i < 16; i++) hold(pat_tab[i], 1'b1, 5);
    check("tp5_wrap", 32'(capture_cnt), 32'h0);

    // Reset mid-settle discards the pending capture
    hold(7'h00, 1'b0, 2);
    hold(7'h66, 1'b1, 2);
    check("tp6_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("tp6_digit", 32'(digit), 32'h0);
    check("tp6_dv",    32'(data_valid), 32'h0);
    check("tp6_busy0", 32'(busy), 32'h0);
    check("tp6_cnt",   32'(capture_cnt), 32'h0);
    cycle_idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    hold(7'h00, 1'b0, 3);

    // Random segments: legal, illegal, blank, with enable dropouts
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 99);
      if (k < 60)      s = pat_tab[$urandom_range(0, 15)];
      else if (k < 80) s = 7'($urandom);
      else             s = 7'h00;
      hold(s, ($urandom_range(0, 99) < 85), $urandom_range(1, 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
